serial_addsub: RTL and testbench

//  Bit-serial two's-complement adder/subtractor built around one full-adder cell and a carry flop.

---
 rtl/serial_addsub_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_addsub.sv | 134 +++++++++++++
 tb/tb_serial_addsub.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bit-counter width; kept at least one bit so a 1-bit counter is still legal.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, used as the one bit slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, one bit per clock, LSB first.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic fa_sum, fa_cout;

  full_adder u_fa (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .carry_in (carry_q),
    .sum      (fa_sum),
    .carry_out(fa_cout)
  );

`ifdef SERIAL_ADDSUB_OVF_EN
  logic msb_cin_q, msb_cin_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    msb_cin_d = msb_cin_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert B and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          s_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        s_d     = {fa_sum, s_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d  = StDone;
          result_d = {fa_sum, s_q[WIDTH-1:1]};
          cout_d   = fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
          msb_cin_d = carry_q;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msb_cin_q <= 1'b0;
    end else begin
      msb_cin_q <= msb_cin_d;
    end
  end

  // Both terms update on the same edge, so the flag only moves on entry to DONE.
  assign overflow = msb_cin_q ^ cout_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH = 8.
module tb_serial_addsub;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  serial_addsub #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; operands are scrambled once accepted.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_sub,
                       output int lat, output bit seen);
    @(negedge clk);
    a = op_a; b = op_b; sub = op_sub; start = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0; a = ~op_a; b = 8'h5C; sub = ~op_sub;
    lat = 1;
    if (done) seen = 1'b1;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #12;
    checks++;
    if ({busy, done, result, carry_out, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, carry_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [W-1:0] va [3] = '{8'h35, 8'hFF, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h4A, 8'h01, 8'h01};
    logic [W-1:0] vr [3] = '{8'h7F, 8'h00, 8'h80};
    bit           vc [3] = '{1'b0, 1'b1, 1'b0};
    bit           vo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, lat, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL add%0d_done: no done pulse within %0d cycles, want one", i, lat);
      end
      if (i == 0) begin
        checks++;
        if (lat != 9) begin
          errors++;
          $display("FAIL add_latency: got %0d cycles, want 9", lat);
        end
      end
      checks++;
      if ({busy, result, carry_out, overflow} !== {1'b1, vr[i], vc[i], vo[i] & OvfEn}) begin
        errors++;
        $display("FAIL add%0d_result: got busy=%b result=%h cout=%b ovf=%b, want 1 %h %b %b",
                 i, busy, result, carry_out, overflow, vr[i], vc[i], vo[i] & OvfEn);
      end
      @(negedge clk);
      checks++;
      if ({busy, done, result} !== {2'b00, vr[i]}) begin
        errors++;
        $display("FAIL add%0d_after: got busy=%b done=%b result=%h, want 0 0 %h",
                 i, busy, done, result, vr[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va [3] = '{8'h10, 8'h80, 8'h5A};
    logic [W-1:0] vb [3] = '{8'h20, 8'h01, 8'h5A};
    logic [W-1:0] vr [3] = '{8'hF0, 8'h7F, 8'h00};
    bit           vc [3] = '{1'b0, 1'b1, 1'b1};
    bit           vo [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b1, lat, seen);
      checks++;
      if (!seen || {result, carry_out, overflow} !== {vr[i], vc[i], vo[i] & OvfEn}) begin
        errors++;
        $display("FAIL sub%0d: got done=%b result=%h cout=%b ovf=%b, want 1 %h %b %b",
                 i, seen, result, carry_out, overflow, vr[i], vc[i], vo[i] & OvfEn);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 8);
      if (start) begin
        a = 8'h7F; b = 8'h01; sub = 1'b1;
      end
      if (done) dones++;
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || result !== 8'h7F || carry_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got dones=%0d result=%h cout=%b busy=%b, want 1 7f 0 0",
               dones, result, carry_out, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit seen;
    bit done_in_reset = 1'b0;
    do_op(8'hFF, 8'h01, 1'b0, lat, seen);  // leaves carry_out=1 held
    @(negedge clk);
    a = 8'h80; b = 8'h80; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, carry_out, overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b result=%h cout=%b ovf=%b, want all 0",
               busy, done, result, carry_out, overflow);
    end
    repeat (2) begin
      @(negedge clk);
      if (done) done_in_reset = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_in_reset = 1'b1;
    end
    checks++;
    if (done_in_reset || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: got stray_done=%b busy=%b, want 0 0", done_in_reset, busy);
    end
    do_op(8'h01, 8'h02, 1'b0, lat, seen);
    checks++;
    if (!seen || {result, carry_out, overflow} !== {8'h03, 2'b00}) begin
      errors++;
      $display("FAIL post_reset_op: got done=%b result=%h cout=%b ovf=%b, want 1 03 0 0",
               seen, result, carry_out, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    do_op(8'h80, 8'h80, 1'b0, lat, seen);
    checks++;
    if (!seen || {result, carry_out, overflow} !== {8'h00, 1'b1, OvfEn}) begin
      errors++;
      $display("FAIL b2b_first: got done=%b result=%h cout=%b ovf=%b, want 1 00 1 %b",
               seen, result, carry_out, overflow, OvfEn);
    end
    // Start raised during the DONE cycle must be dropped.
    a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_start: got busy=%b, want 0", busy);
    end
    do_op(8'h35, 8'h4A, 1'b0, lat, seen);
    checks++;
    if (!seen || lat != 9 || {result, carry_out, overflow} !== {8'h7F, 2'b00}) begin
      errors++;
      $display("FAIL b2b_second: got done=%b lat=%0d result=%h cout=%b ovf=%b, want 1 9 7f 0 0",
               seen, lat, result, carry_out, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
